// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with press/release debounce.
//
// The scanner drives one column low at a time. When the synchronized rows show a
// single key on the active column, the column is frozen while the press is
// debounced. An accepted press loads the key code, pulses key_valid for one
// cycle and raises key_held. key_held stays high until a release has been
// debounced. Scanning then restarts at column 0.
//
// Parameters:
//   SCAN_DIV      clk cycles each column is driven while scanning
//   DEBOUNCE_CNT  consecutive stable clk cycles that accept a press or release
//   REPEAT_DLY    (KEYPAD_AUTOREPEAT_EN only) cycles from acceptance to first repeat
//   REPEAT_PER    (KEYPAD_AUTOREPEAT_EN only) cycles between later repeats
//
// Configuration macro: KEYPAD_AUTOREPEAT_EN
//   When this macro is defined, a held key re-pulses key_valid, with the same
//   code, after REPEAT_DLY cycles and then every REPEAT_PER cycles.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   row[3:0]   in   keypad rows, active-low, externally pulled up
//   col[3:0]   out  column drive, active-low, exactly one bit low
//   key[3:0]   out  code of the last accepted key
//   key_valid  out  one-cycle pulse, key is valid in the same cycle
//   key_held   out  high while the accepted key remains pressed
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter logic [24:0] REPEAT_DLY   = 25'd25000000,
  parameter logic [24:0] REPEAT_PER   = 25'd5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t      state_r;
  logic [3:0]  sync1_r;
  logic [3:0]  rs_r;
  logic [15:0] div_cnt_r;
  logic [19:0] deb_cnt_r;
  logic [1:0]  col_idx_r;
  logic [1:0]  row_idx_r;
  logic [3:0]  pat_r;
  logic [3:0]  col_r;
  logic [3:0]  key_r;
  logic        key_valid_r;
  logic        key_held_r;
  logic [1:0]  next_col_s;
  logic        dwell_done_s;
  logic        deb_done_s;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [24:0] rep_cnt_r;
  logic        rep_on_r;
  logic        rep_fire_s;
`endif

  // True when exactly one row is pulled low. Multi-key and idle patterns are rejected.
  function automatic logic single_low(input logic [3:0] v);
    logic r;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Index of the single low bit. Only meaningful when single_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Active-low column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = 4'b1110;
      2'd1:    r = 4'b1101;
      2'd2:    r = 4'b1011;
      2'd3:    r = 4'b0111;
      default: r = 4'b1110;
    endcase
    return r;
  endfunction

  // Keypad legend. Operator keys are coded A=+, B=-, C=%, D=*, E='=' and F=/.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = 4'hF;
      4'hD:    k = 4'h0;
      4'hE:    k = 4'hE;
      4'hF:    k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  // Terminal counts use >= so that a counter cannot run past its limit and wrap.
  assign next_col_s   = col_idx_r + 2'd1;
  assign dwell_done_s = (div_cnt_r >= (SCAN_DIV - 16'd1));
  assign deb_done_s   = (deb_cnt_r >= (DEBOUNCE_CNT - 20'd1));
`ifdef KEYPAD_AUTOREPEAT_EN
  assign rep_fire_s   = rep_on_r ? (rep_cnt_r >= (REPEAT_PER - 25'd1))
                                 : (rep_cnt_r >= (REPEAT_DLY - 25'd1));
`endif

  // Two-flop synchronizer on the asynchronous row inputs. Idle is all-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'hF;
      rs_r    <= 4'hF;
    end else begin
      sync1_r <= row;
      rs_r    <= sync1_r;
    end
  end

  // Scan / debounce state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= SCAN;
      div_cnt_r   <= 16'd0;
      deb_cnt_r   <= 20'd0;
      col_idx_r   <= 2'd0;
      row_idx_r   <= 2'd0;
      pat_r       <= 4'hF;
      col_r       <= 4'b1110;
      key_r       <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_r   <= 25'd0;
      rep_on_r    <= 1'b0;
`endif
    end else begin
      key_valid_r <= 1'b0;
      case (state_r)
        SCAN: begin
          if (dwell_done_s) begin
            div_cnt_r <= 16'd0;
            if (single_low(rs_r)) begin
              // Freeze the column by leaving col_r alone. Remember which row answered.
              row_idx_r <= low_index(rs_r);
              pat_r     <= rs_r;
              deb_cnt_r <= 20'd0;
              state_r   <= DEB_PRESS;
            end else begin
              col_idx_r <= next_col_s;
              col_r     <= col_drive(next_col_s);
            end
          end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
          end
        end
        DEB_PRESS: begin
          if (rs_r != pat_r) begin
            // Bounce: give up and resume scanning at the next column.
            deb_cnt_r <= 20'd0;
            div_cnt_r <= 16'd0;
            col_idx_r <= next_col_s;
            col_r     <= col_drive(next_col_s);
            state_r   <= SCAN;
          end else if (deb_done_s) begin
            deb_cnt_r   <= 20'd0;
            key_r       <= key_code(row_idx_r, col_idx_r);
            key_valid_r <= 1'b1;
            key_held_r  <= 1'b1;
            state_r     <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_r   <= 25'd0;
            rep_on_r    <= 1'b0;
`endif
          end else begin
            deb_cnt_r <= deb_cnt_r + 20'd1;
          end
        end
        PRESSED: begin
          // Only all-high counts as a release. A second key leaves rs non-idle and is ignored.
          if (rs_r == 4'hF) begin
            deb_cnt_r <= 20'd0;
            state_r   <= DEB_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_r <= 25'd0;
            rep_on_r  <= 1'b0;
`endif
          end else begin
            deb_cnt_r <= 20'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_fire_s) begin
              key_valid_r <= 1'b1;
              rep_cnt_r   <= 25'd0;
              rep_on_r    <= 1'b1;
            end else begin
              rep_cnt_r <= rep_cnt_r + 25'd1;
            end
`endif
          end
        end
        DEB_RELEASE: begin
          if (rs_r != 4'hF) begin
            deb_cnt_r <= 20'd0;
            state_r   <= PRESSED;
          end else if (deb_done_s) begin
            deb_cnt_r  <= 20'd0;
            key_held_r <= 1'b0;
            div_cnt_r  <= 16'd0;
            col_idx_r  <= 2'd0;
            col_r      <= 4'b1110;
            state_r    <= SCAN;
          end else begin
            deb_cnt_r <= deb_cnt_r + 20'd1;
          end
        end
        default: begin
          state_r    <= SCAN;
          div_cnt_r  <= 16'd0;
          deb_cnt_r  <= 20'd0;
          col_idx_r  <= 2'd0;
          col_r      <= 4'b1110;
          key_held_r <= 1'b0;
        end
      endcase
    end
  end

  assign col       = col_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Randomized, scoreboard-checked bench for keypad_scanner.
// A physical keypad model turns the set of pressed switches and the column drive
// into row levels. Every press that must be accepted pushes its code into a queue.
// A monitor pops that queue on each key_valid pulse.
module tb_keypad_scanner;

  localparam int SCAN_DIV_I = 4;
  localparam int DEB_I      = 8;
  localparam int REP_DLY_I  = 20;
  localparam int REP_PER_I  = 6;

  // Legend indexed by row*4+col.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hF, 4'h0, 4'hE, 4'hD
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0;   // bit row*4+col = switch closed

  int          checks = 0;
  int          failures = 0;
  int          col_bad = 0;
  int unsigned cyc = 0;
  logic [3:0]  exp_q[$];
  int unsigned pulse_t[$];
  logic [3:0]  mon_exp;

  keypad_scanner #(
    .SCAN_DIV(16'(SCAN_DIV_I)),
    .DEBOUNCE_CNT(20'(DEB_I))
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DLY(25'(REP_DLY_I)),
    .REPEAT_PER(25'(REP_PER_I))
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a closed switch pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every key_valid pulse against the scoreboard queue.
  always @(negedge clk) begin
    if ($countones(~col) != 1) col_bad++;
    if (reset && key_valid) begin
      pulse_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual key=%0h expected=no pulse (t=%0t)", key, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse_key", int'(key), int'(mon_exp));
      end
      check("held_with_valid", int'(key_held), 1);
    end
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Press (r,c), wait for acceptance, hold `extra` cycles, release, and check the release window.
  task automatic press_and_release(input int r, input int c, input int extra);
    logic got;
    logic early;
    exp_q.push_back(KEYMAP[r*4+c]);
    pressed[r*4+c] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = key_held;
    end
    check("press_accept", int'(got), 1);
    repeat (extra) @(negedge clk);
    pressed = 16'h0;
    early = 1'b0;
    for (int t = 0; t < DEB_I; t++) begin
      @(negedge clk);
      if (!key_held) early = 1'b1;
    end
    check("held_min_release", int'(early), 0);
    got = 1'b1;
    for (int t = 0; t < 6 && got; t++) begin
      @(negedge clk);
      got = key_held;
    end
    check("held_drop", int'(got), 0);
    check("key_kept", int'(key), int'(KEYMAP[r*4+c]));
  endtask

  initial begin
    logic [3:0] one4;
    logic [3:0] col_exp;
    logic       got;
    logic       saw_last_col;
    logic       held_seen;
    int         run;
    int         off;
    int         exp_off[$];

    one4 = 4'b0001;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_col", int'(col), int'(4'b1110));
    check("rst_key", int'(key), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);

    // Idle scan: each column is held SCAN_DIV cycles, starting at column 0.
    reset = 1'b1;
    for (int n = 0; n < 32; n++) begin
      col_exp = ~(one4 << ((n / SCAN_DIV_I) % 4));
      check("scan_col", int'(col), int'(col_exp));
      check("scan_no_valid", int'(key_valid), 0);
      @(negedge clk);
    end

    // "6" (row1/col2) held, then released.
    press_and_release(1, 2, 10);
    repeat (5) @(negedge clk);

    // Random keys with random hold/idle times. Holds stay short of any repeat delay.
    for (int i = 0; i < 12; i++) begin
      press_and_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 10)));
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end

    // "=" (row3/col2) with 3-cycle bounces on press and on release.
    exp_q.push_back(4'hE);
    for (int k = 0; k < 4; k++) begin
      pressed[14] = 1'b1;
      repeat (3) @(negedge clk);
      pressed[14] = 1'b0;
      repeat (3) @(negedge clk);
    end
    pressed[14] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = key_held;
    end
    check("bounce_accept", int'(got), 1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pressed[14] = 1'b0;
      repeat (3) @(negedge clk);
      pressed[14] = 1'b1;
      repeat (3) @(negedge clk);
    end
    pressed = 16'h0;
    got = 1'b1;
    for (int t = 0; t < 40 && got; t++) begin
      @(negedge clk);
      got = key_held;
    end
    check("bounce_release", int'(got), 0);
    check("bounce_key", int'(key), int'(4'hE));
    repeat (4) @(negedge clk);

    // Rows 0 and 2 both low on column 0: ambiguous, never accepted, and scanning continues.
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    saw_last_col = 1'b0;
    held_seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (col == 4'b0111) saw_last_col = 1'b1;
      if (key_held) held_seen = 1'b1;
    end
    check("multi_scan_continues", int'(saw_last_col), 1);
    check("multi_no_held", int'(held_seen), 0);
    pressed = 16'h0;
    repeat (6) @(negedge clk);

    // "D" (row3/col3) held 45 cycles after acceptance. Check pulse spacing.
    pulse_t.delete();
    exp_off.delete();
    exp_off.push_back(0);
`ifdef KEYPAD_AUTOREPEAT_EN
    off = REP_DLY_I;
    while (off < 45) begin
      exp_off.push_back(off);
      off += REP_PER_I;
    end
`else
    off = 0;
`endif
    for (int i = 0; i < exp_off.size(); i++) exp_q.push_back(4'hD);
    pressed[15] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = key_held;
    end
    check("d_accept", int'(got), 1);
    repeat (45) @(negedge clk);
    pressed = 16'h0;
    got = 1'b1;
    for (int t = 0; t < 20 && got; t++) begin
      @(negedge clk);
      got = key_held;
    end
    check("d_release", int'(got), 0);
    check("d_pulse_count", pulse_t.size(), exp_off.size());
    for (int i = 0; i < exp_off.size() && i < pulse_t.size(); i++)
      check("d_pulse_offset", int'(pulse_t[i] - pulse_t[0]), exp_off[i]);
    repeat (4) @(negedge clk);

    // Reset during the debounce of "5" (row1/col1): abort with no pulse.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pressed[5] = 1'b1;
    reset = 1'b1;
    run = 0;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (col == 4'b1101) run++;
      else run = 0;
      if (run > SCAN_DIV_I) got = 1'b1;
    end
    check("deb5_col_frozen", int'(got), 1);
    check("deb5_not_yet_held", int'(key_held), 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_col", int'(col), int'(4'b1110));
    check("abort_key", int'(key), 0);
    check("abort_valid", int'(key_valid), 0);
    check("abort_held", int'(key_held), 0);
    pressed = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_restart_col", int'(col), int'(4'b1110));
    repeat (30) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    check("col_one_low", col_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
